// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-enable scheduler.
// The state encoding and ratio clamp are shared by the controller and its interface.
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } state_t;

  localparam int unsigned DefaultCntW = 8;

  // A zero ratio would never wrap, so it is treated as divide-by-one.
  function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
    return (ratio == 32'd0) ? 32'd1 : ratio;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control, config and status bundle of clk_div_ctrl.
// The master drives the requests; the slave returns the strobe and status.
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
);

  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_ratio;
  logic             cfg_ready;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_ratio;
  logic [CNT_W-1:0] phase;

  modport master (
    output start, stop, cfg_valid, cfg_ratio,
    input  cfg_ready, tick, busy, cur_ratio, phase
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_ratio,
    output cfg_ready, tick, busy, cur_ratio, phase
  );

endinterface

// File: rtl/clk_div_mod_cnt.sv
// Modulo counter with enable and synchronous clear.
// It counts 0..modulus_i-1 and flags the last count with wrap_o.
module clk_div_mod_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] modulus_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == (modulus_i - CNT_W'(1)));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable tick scheduler: a one-cycle tick every cur_ratio cycles while running.
// Ratio changes and stops land only on period boundaries, so no period is ever truncated.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W         = DefaultCntW,
  parameter int unsigned DEFAULT_RATIO = 16
) (
  input logic               clk,
  input logic               rst,
  clk_div_ctrl_if.slave     bus
);

  state_t           state_q, state_d;
  logic             tick_q, tick_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [CNT_W-1:0] cur_ratio_q, cur_ratio_d;
  logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
  logic             pend_valid_q, pend_valid_d;

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             cnt_en;
  logic             cfg_acc;
  logic [CNT_W-1:0] cfg_ratio_clamped;

  assign cnt_en            = (state_q != StIdle);
  assign cfg_acc           = bus.cfg_valid && cfg_ready_q;
  assign cfg_ratio_clamped = CNT_W'(clamp_ratio(32'(bus.cfg_ratio)));

  clk_div_mod_cnt #(
    .CNT_W(CNT_W)
  ) u_mod_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .en_i     (cnt_en),
    .clr_i    (!cnt_en),
    .modulus_i(cur_ratio_q),
    .cnt_o    (cnt),
    .wrap_o   (wrap)
  );

  always_comb begin
    state_d      = state_q;
    tick_d       = 1'b0;
    cur_ratio_d  = cur_ratio_q;
    pend_ratio_d = pend_ratio_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          tick_d  = 1'b1;
        end
      end
      StRun: begin
        if (bus.stop) begin
          state_d = wrap ? StIdle : StStopping;
        end else begin
          tick_d = wrap;
        end
      end
      StStopping: begin
        if (wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StIdle) begin
      if (cfg_acc) begin
        cur_ratio_d = cfg_ratio_clamped;
      end
    end else begin
      if (wrap && pend_valid_q) begin
        cur_ratio_d  = pend_ratio_q;
        pend_valid_d = 1'b0;
      end
      // An accept on the wrap cycle itself waits for the following wrap.
      if (cfg_acc) begin
        pend_ratio_d = cfg_ratio_clamped;
        pend_valid_d = 1'b1;
      end
      // Nothing may stay pending in idle: there is no later wrap to apply it.
      if ((state_d == StIdle) && pend_valid_d) begin
        cur_ratio_d  = pend_ratio_d;
        pend_valid_d = 1'b0;
      end
    end

    // Held low through the first cycle of the new period after a pending value lands.
    cfg_ready_d = (state_d == StIdle) || !(pend_valid_d || pend_valid_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      tick_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cur_ratio_q  <= CNT_W'(DEFAULT_RATIO);
      pend_ratio_q <= CNT_W'(1);
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      cfg_ready_q  <= cfg_ready_d;
      cur_ratio_q  <= cur_ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cur_ratio = cur_ratio_q;
  assign bus.phase     = cnt;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a cycle-indexed reference model queues the expected
// status for every clock, and an independent monitor pops and compares each cycle.
module tb_clk_div_ctrl;

  localparam int unsigned CntW  = 8;
  localparam int          Never = 1 << 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.CNT_W(CntW)) bus ();

  clk_div_ctrl #(
    .CNT_W        (CntW),
    .DEFAULT_RATIO(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       tick;
    logic       busy;
    logic [7:0] phase;
    logic [7:0] ratio;
    logic       ready;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model in absolute cycle numbers: a period started at m_pstart has phase
  // (cycle - m_pstart) and ends when that reaches ratio-1.
  int m_cyc, m_pstart, m_ratio, m_ready_from;
  bit m_busy, m_stopping, m_acc;
  int m_pend[$];

  task automatic model_reset();
    m_cyc        = 0;
    m_pstart     = 0;
    m_ratio      = 16;
    m_ready_from = 0;
    m_busy       = 1'b0;
    m_stopping   = 1'b0;
    m_acc        = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_step(input bit s, input bit p, input bit v, input int r);
    int c, nr;
    bit last, tick_n;
    obs_t e;
    c     = m_cyc;
    m_acc = v && (!m_busy || (c >= m_ready_from));
    nr    = (r == 0) ? 1 : r;
    last  = m_busy && ((c - m_pstart) == (m_ratio - 1));
    tick_n = 1'b0;
    if (!m_busy) begin
      if (m_acc) m_ratio = nr;
      if (s) begin
        m_busy       = 1'b1;
        m_stopping   = 1'b0;
        m_pstart     = c + 1;
        m_ready_from = 0;
        tick_n       = 1'b1;
      end
    end else begin
      if (last && (m_pend.size() > 0)) begin
        m_ratio      = m_pend.pop_front();
        m_ready_from = c + 2;
      end
      if (m_acc) begin
        m_pend.push_back(nr);
        m_ready_from = Never;
      end
      if (last) begin
        m_pstart = c + 1;
        if (m_stopping || p) begin
          m_busy = 1'b0;
          if (m_pend.size() > 0) m_ratio = m_pend.pop_front();
        end else begin
          tick_n = 1'b1;
        end
      end else if (p) begin
        m_stopping = 1'b1;
      end
    end
    m_cyc   = c + 1;
    e.tick  = tick_n;
    e.busy  = m_busy;
    e.phase = m_busy ? 8'(m_cyc - m_pstart) : 8'd0;
    e.ratio = 8'(m_ratio);
    e.ready = !m_busy || (m_cyc >= m_ready_from);
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit s, input bit p, input bit v, input int r);
    @(negedge clk);
    bus.start     = s;
    bus.stop      = p;
    bus.cfg_valid = v;
    bus.cfg_ratio = 8'(r);
    model_step(s, p, v, r);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic stop_to_idle();
    drive(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; (i < 600) && m_busy; i++) drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    @(negedge clk);
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ratio = '0;
    #1;
    check_val("rst_tick", int'(bus.tick), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_phase", int'(bus.phase), 0);
    check_val("rst_cur_ratio", int'(bus.cur_ratio), 16);
    check_val("rst_cfg_ready", int'(bus.cfg_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Monitor: one expected observation per modelled clock edge.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (rst && (exp_q.size() > 0)) begin
        e   = exp_q.pop_front();
        got = '{bus.tick, bus.busy, bus.phase, bus.cur_ratio, bus.cfg_ready};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL obs t=%0t: got tick=%b busy=%b phase=%0d ratio=%0d ready=%b, expected tick=%b busy=%b phase=%0d ratio=%0d ready=%b",
                   $time, got.tick, got.busy, got.phase, got.ratio, got.ready,
                   e.tick, e.busy, e.phase, e.ratio, e.ready);
        end
      end
    end
  end

  initial begin
    int n;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ratio = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_val("init_tick", int'(bus.tick), 0);
    check_val("init_busy", int'(bus.busy), 0);
    check_val("init_cur_ratio", int'(bus.cur_ratio), 16);
    check_val("init_cfg_ready", int'(bus.cfg_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    // Ratio 0 clamps to 1: tick every cycle, phase pinned at 0.
    drive(1'b0, 1'b0, 1'b1, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    idle_n(10);
    stop_to_idle();

    // Live reconfig 4 -> 3: ticks 1, 5, 9, 12, 15; ready low 7..9.
    drive(1'b0, 1'b0, 1'b1, 4);
    drive(1'b1, 1'b0, 1'b0, 0);
    idle_n(5);
    drive(1'b0, 1'b0, 1'b1, 3);
    idle_n(14);
    mid_reset();

    // Default ratio after reset: ticks at 1, 17, 33.
    drive(1'b1, 1'b0, 1'b0, 0);
    idle_n(40);
    stop_to_idle();

    // Back-to-back config: 5 accepted at once, 7 held until ready returns.
    drive(1'b0, 1'b0, 1'b1, 4);
    drive(1'b1, 1'b0, 1'b0, 0);
    idle_n(1);
    drive(1'b0, 1'b0, 1'b1, 5);
    n = 0;
    do begin
      drive(1'b0, 1'b0, 1'b1, 7);
      n++;
    end while (!m_acc && (n < 50));
    idle_n(20);
    stop_to_idle();

    // Stop mid-period and on the wrap cycle with ratio 8.
    drive(1'b0, 1'b0, 1'b1, 8);
    drive(1'b1, 1'b0, 1'b0, 0);
    idle_n(2);
    stop_to_idle();
    idle_n(2);
    drive(1'b1, 1'b0, 1'b0, 0);
    idle_n(7);
    drive(1'b0, 1'b1, 1'b0, 0);
    idle_n(3);

    // start+stop together: start wins in idle, stop wins in run; pending lands at idle.
    drive(1'b1, 1'b1, 1'b0, 0);
    idle_n(3);
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; (i < 600) && m_busy; i++) drive(1'b0, 1'b0, 1'b0, 0);
    idle_n(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = (($urandom % 20) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      if (($urandom % 700) == 0) begin
        mid_reset();
      end else begin
        drive(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 4) == 0, r);
      end
    end
    stop_to_idle();
    idle_n(2);

    @(negedge clk);
    @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
